// File: rtl/psec6_spi_pkg.sv
// PSEC6 slow-control SPI target: shared address map and instruction codes.
// Build option PSEC6_SPI_STATUS_REG_EN maps a read-only status byte at addr 0.
package psec6_spi_pkg;

    localparam int RW_BIT = 7;

    localparam logic [6:0] ADDR_STATUS = 7'd0;
    localparam logic [6:0] ADDR_VCO    = 7'd1;
    localparam logic [6:0] ADDR_MASK   = 7'd2;
    localparam logic [6:0] ADDR_INST   = 7'd3;
    localparam logic [6:0] ADDR_MODE   = 7'd4;
    localparam logic [6:0] ADDR_POL    = 7'd5;
    localparam logic [6:0] ADDR_REFCLK = 7'd6;
    localparam logic [6:0] ADDR_SLOW   = 7'd7;
    localparam logic [6:0] ADDR_DELAY  = 7'd8;
    localparam logic [6:0] ADDR_PLLSW  = 7'd9;
    localparam logic [6:0] ADDR_SELECT = 7'd10;

    localparam logic [7:0] INST_RST     = 8'd1;
    localparam logic [7:0] INST_READOUT = 8'd2;
    localparam logic [7:0] INST_START   = 8'd3;

endpackage

// File: rtl/psec6_spi_shift.sv
// Serial front end: bit counter, input shifter, read-word capture and
// falling-edge POCI driver. cs low or rstn low clears it asynchronously.
module psec6_spi_shift
    import psec6_spi_pkg::*;
#(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8
) (
    input  logic              spi_clk,
    input  logic              rstn,
    input  logic              cs,
    input  logic              pico,
    input  logic [DATA_W-1:0] rd_data,
    output logic              poci,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              wr_stb,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data
);
    localparam int HDR_W = ADDR_W + 1;
    localparam int NBITS = HDR_W + DATA_W;
    localparam int CW    = $clog2(NBITS + 1);
    localparam int IW    = $clog2(DATA_W);

    logic              clr_n;
    logic [CW-1:0]     cnt;
    logic [NBITS-2:0]  sr;
    logic [DATA_W-1:0] tx;
    logic              rd;
    logic [HDR_W-1:0]  hdr_now;
    logic [HDR_W-1:0]  hdr_done;
    logic [IW-1:0]     idx;

    assign clr_n    = rstn & cs;
    // hdr_now is the header as it completes on the 8th edge
    assign hdr_now  = {sr[HDR_W-2:0], pico};
    assign hdr_done = sr[NBITS-2 -: HDR_W];
    assign rd_addr  = hdr_now[ADDR_W-1:0];
    assign wr_addr  = hdr_done[ADDR_W-1:0];
    assign wr_data  = {sr[DATA_W-2:0], pico};
    assign wr_stb   = (cnt == CW'(NBITS - 1)) & hdr_done[RW_BIT];
    assign idx      = IW'(CW'(NBITS - 1) - cnt);

    always_ff @(posedge spi_clk or negedge clr_n) begin
        if (!clr_n) begin
            cnt <= '0;
            sr  <= '0;
            tx  <= '0;
            rd  <= 1'b0;
        end else if (cnt != CW'(NBITS)) begin
            cnt <= cnt + 1'b1;
            sr  <= {sr[NBITS-3:0], pico};
            if (cnt == CW'(HDR_W - 1)) begin
                rd <= ~hdr_now[RW_BIT];
                tx <= rd_data;
            end
        end
    end

    // after the last data bit the counter saturates and poci holds bit 0
    always_ff @(negedge spi_clk or negedge clr_n) begin
        if (!clr_n) begin
            poci <= 1'b0;
        end else if (!rd) begin
            poci <= 1'b0;
        end else if (cnt != CW'(NBITS)) begin
            poci <= tx[idx];
        end
    end

endmodule

// File: rtl/psec6_spi.sv
// PSEC6 SPI target: register file, instruction decode and clk_enable flag.
// Build option PSEC6_SPI_STATUS_REG_EN maps a read-only status byte at addr 0.
module psec6_spi
    import psec6_spi_pkg::*;
#(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8
) (
    input  logic       spi_clk,
    input  logic       rstn,
    input  logic       pico,
    input  logic       cs,
    input  logic       trigger_in,
    input  logic       pll_locked,
    output logic       poci_spi,
    output logic       clk_enable,
    output logic [5:0] vco_digital_band,
    output logic [4:0] ref_clk_sel,
    output logic       slow_mode,
    output logic       pll_switch,
    output logic [7:0] trigger_channel_mask,
    output logic [1:0] mode,
    output logic [7:0] disc_polarity,
    output logic [5:0] trigger_delay,
    output logic [2:0] select_reg,
    output logic       inst_rst,
    output logic       inst_readout,
    output logic       inst_start
);
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] rd_data;
    logic              wr_stb;
    logic [7:0]        inst_reg;
    logic              flag;
    logic              flag_clr_n;
    logic              inst_wr;

    psec6_spi_shift #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_shift (
        .spi_clk (spi_clk),
        .rstn    (rstn),
        .cs      (cs),
        .pico    (pico),
        .rd_data (rd_data),
        .poci    (poci_spi),
        .rd_addr (rd_addr),
        .wr_stb  (wr_stb),
        .wr_addr (wr_addr),
        .wr_data (wr_data)
    );

    assign inst_wr = wr_stb & (wr_addr == ADDR_INST);

    always_ff @(posedge spi_clk or negedge rstn) begin
        if (!rstn) begin
            vco_digital_band     <= '0;
            trigger_channel_mask <= '0;
            inst_reg             <= '0;
            mode                 <= '0;
            disc_polarity        <= '0;
            ref_clk_sel          <= '0;
            slow_mode            <= 1'b0;
            trigger_delay        <= '0;
            pll_switch           <= 1'b0;
            select_reg           <= '0;
            inst_rst             <= 1'b0;
            inst_readout         <= 1'b0;
            inst_start           <= 1'b0;
        end else if (wr_stb) begin
            case (wr_addr)
                ADDR_VCO:    vco_digital_band     <= wr_data[5:0];
                ADDR_MASK:   trigger_channel_mask <= wr_data[7:0];
                ADDR_MODE:   mode                 <= wr_data[1:0];
                ADDR_POL:    disc_polarity        <= wr_data[7:0];
                ADDR_REFCLK: ref_clk_sel          <= wr_data[4:0];
                ADDR_SLOW:   slow_mode            <= wr_data[0];
                ADDR_DELAY:  trigger_delay        <= wr_data[5:0];
                ADDR_PLLSW:  pll_switch           <= wr_data[0];
                ADDR_SELECT: select_reg           <= wr_data[2:0];
                ADDR_INST: begin
                    inst_reg     <= wr_data[7:0];
                    inst_rst     <= (wr_data[7:0] == INST_RST);
                    inst_readout <= (wr_data[7:0] == INST_READOUT);
                    inst_start   <= (wr_data[7:0] == INST_START);
                end
                default: ;
            endcase
        end
    end

    // trigger_in holds the flag cleared, so it also wins over a START write
    assign flag_clr_n = rstn & ~trigger_in;

    always_ff @(posedge spi_clk or negedge flag_clr_n) begin
        if (!flag_clr_n) begin
            flag <= 1'b0;
        end else if (inst_wr) begin
            if (wr_data[7:0] == INST_START) begin
                flag <= 1'b1;
            end else if (wr_data[7:0] == INST_RST) begin
                flag <= 1'b0;
            end
        end
    end

    assign clk_enable = flag & (pll_locked | ~pll_switch);

    always_comb begin
        rd_data = '0;
        case (rd_addr)
`ifdef PSEC6_SPI_STATUS_REG_EN
            ADDR_STATUS: rd_data[1:0] = {pll_locked, clk_enable};
`endif
            ADDR_VCO:    rd_data[5:0] = vco_digital_band;
            ADDR_MASK:   rd_data[7:0] = trigger_channel_mask;
            ADDR_INST:   rd_data[7:0] = inst_reg;
            ADDR_MODE:   rd_data[1:0] = mode;
            ADDR_POL:    rd_data[7:0] = disc_polarity;
            ADDR_REFCLK: rd_data[4:0] = ref_clk_sel;
            ADDR_SLOW:   rd_data[0]   = slow_mode;
            ADDR_DELAY:  rd_data[5:0] = trigger_delay;
            ADDR_PLLSW:  rd_data[0]   = pll_switch;
            ADDR_SELECT: rd_data[2:0] = select_reg;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_psec6_spi.sv
// Scoreboard bench for psec6_spi: SPI host tasks plus a register-map model.
module tb_psec6_spi;

    logic       spi_clk;
    logic       rstn;
    logic       pico;
    logic       cs;
    logic       trigger_in;
    logic       pll_locked;
    logic       poci_spi;
    logic       clk_enable;
    logic [5:0] vco_digital_band;
    logic [4:0] ref_clk_sel;
    logic       slow_mode;
    logic       pll_switch;
    logic [7:0] trigger_channel_mask;
    logic [1:0] mode;
    logic [7:0] disc_polarity;
    logic [5:0] trigger_delay;
    logic [2:0] select_reg;
    logic       inst_rst;
    logic       inst_readout;
    logic       inst_start;

    int total = 0;
    int bad   = 0;

    logic [15:0] exp_q[$];
    logic [7:0]  m_reg[0:15];
    logic        m_flag;

    psec6_spi dut (
        .spi_clk              (spi_clk),
        .rstn                 (rstn),
        .pico                 (pico),
        .cs                   (cs),
        .trigger_in           (trigger_in),
        .pll_locked           (pll_locked),
        .poci_spi             (poci_spi),
        .clk_enable           (clk_enable),
        .vco_digital_band     (vco_digital_band),
        .ref_clk_sel          (ref_clk_sel),
        .slow_mode            (slow_mode),
        .pll_switch           (pll_switch),
        .trigger_channel_mask (trigger_channel_mask),
        .mode                 (mode),
        .disc_polarity        (disc_polarity),
        .trigger_delay        (trigger_delay),
        .select_reg           (select_reg),
        .inst_rst             (inst_rst),
        .inst_readout         (inst_readout),
        .inst_start           (inst_start)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int m_width(input logic [6:0] a);
        case (a)
            7'd1: return 6;
            7'd2: return 8;
            7'd3: return 8;
            7'd4: return 2;
            7'd5: return 8;
            7'd6: return 5;
            7'd7: return 1;
            7'd8: return 6;
            7'd9: return 1;
            7'd10: return 3;
            default: return 0;
        endcase
    endfunction

    function automatic logic m_ce();
        return m_flag & (pll_locked | ~m_reg[9][0]);
    endfunction

    function automatic logic [7:0] m_read(input logic [6:0] a);
        logic [7:0] v;
        v = 8'h00;
`ifdef PSEC6_SPI_STATUS_REG_EN
        if (a == 7'd0) v = {6'b0, pll_locked, m_ce()};
`endif
        if (a < 7'd16) v = v | m_reg[a[3:0]];
        return v;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 16; i++) m_reg[i] = 8'h00;
        m_flag = 1'b0;
    endtask

    task automatic m_write(input logic [6:0] a, input logic [7:0] d);
        int w;
        w = m_width(a);
        if (w > 0) m_reg[a[3:0]] = d & 8'((1 << w) - 1);
        if (a == 7'd3) begin
            if (d == 8'd3 && !trigger_in) m_flag = 1'b1;
            else if (d == 8'd1) m_flag = 1'b0;
        end
    endtask

    task automatic xfer(input logic [7:0] b0, input logic [7:0] b1,
                        input int nbits, output logic [15:0] rx,
                        output logic last);
        logic [23:0] w;
        w  = {b0, b1, 8'hFF};
        rx = '0;
        cs = 1'b1;
        #10;
        for (int i = 0; i < nbits; i++) begin
            pico = w[23-i];
            #5;
            if (i < 16) rx[15-i] = poci_spi;
            spi_clk = 1'b1;
            #10;
            spi_clk = 1'b0;
            #5;
        end
        #5;
        last = poci_spi;
        cs   = 1'b0;
        pico = 1'b0;
        #10;
    endtask

    task automatic spi_wr(input logic [6:0] a, input logic [7:0] d,
                          input int nbits);
        logic [15:0] rx;
        logic        last;
        exp_q.push_back(16'h0000);
        xfer({1'b1, a}, d, nbits, rx, last);
        chk("wr_poci", {16'h0, rx}, {16'h0, exp_q.pop_front()});
        if (nbits >= 16) m_write(a, d);
    endtask

    task automatic spi_rd(input logic [6:0] a);
        logic [15:0] rx;
        logic        last;
        logic [7:0]  e;
        e = m_read(a);
        exp_q.push_back({8'h00, e});
        xfer({1'b0, a}, 8'h5A, 16, rx, last);
        chk($sformatf("rd_a%0d", a), {16'h0, rx}, {16'h0, exp_q.pop_front()});
        chk("rd_hold", {31'h0, last}, {31'h0, e[0]});
    endtask

    task automatic check_outs(input string tag);
        chk({tag, "_vco"},   {26'h0, vco_digital_band},     {24'h0, m_reg[1]});
        chk({tag, "_mask"},  {24'h0, trigger_channel_mask}, {24'h0, m_reg[2]});
        chk({tag, "_mode"},  {30'h0, mode},                 {24'h0, m_reg[4]});
        chk({tag, "_pol"},   {24'h0, disc_polarity},        {24'h0, m_reg[5]});
        chk({tag, "_ref"},   {27'h0, ref_clk_sel},          {24'h0, m_reg[6]});
        chk({tag, "_slow"},  {31'h0, slow_mode},            {24'h0, m_reg[7]});
        chk({tag, "_dly"},   {26'h0, trigger_delay},        {24'h0, m_reg[8]});
        chk({tag, "_pllsw"}, {31'h0, pll_switch},           {24'h0, m_reg[9]});
        chk({tag, "_sel"},   {29'h0, select_reg},           {24'h0, m_reg[10]});
        chk({tag, "_irst"},  {31'h0, inst_rst},    {31'h0, m_reg[3] == 8'd1});
        chk({tag, "_iro"},   {31'h0, inst_readout}, {31'h0, m_reg[3] == 8'd2});
        chk({tag, "_istart"}, {31'h0, inst_start}, {31'h0, m_reg[3] == 8'd3});
        chk({tag, "_ce"},    {31'h0, clk_enable},  {31'h0, m_ce()});
        chk({tag, "_poci"},  {31'h0, poci_spi},    32'h0);
    endtask

    initial begin
        spi_clk    = 1'b0;
        rstn       = 1'b0;
        pico       = 1'b0;
        cs         = 1'b0;
        trigger_in = 1'b0;
        pll_locked = 1'b0;
        m_reset();
        #30;
        rstn = 1'b1;
        #10;
        check_outs("reset");

        spi_wr(7'd1, 8'h03, 16);
        chk("vco3", {26'h0, vco_digital_band}, 32'd3);

        spi_wr(7'd3, 8'h03, 16);
        chk("start_ce", {31'h0, clk_enable}, 32'd1);
        check_outs("start");

        trigger_in = 1'b1;
        #25;
        trigger_in = 1'b0;
        #5;
        m_flag = 1'b0;
        chk("trig_ce", {31'h0, clk_enable}, 32'd0);
        check_outs("trig");

        spi_rd(7'd1);

        spi_wr(7'd3, 8'h01, 16);
        chk("irst", {31'h0, inst_rst}, 32'd1);
        spi_wr(7'd3, 8'h02, 16);
        chk("iro", {31'h0, inst_readout}, 32'd1);
        check_outs("inst");

        spi_wr(7'd2, 8'hFF, 12);
        chk("partial", {24'h0, trigger_channel_mask}, 32'h00);
        spi_wr(7'd2, 8'hA5, 16);
        chk("mask_a5", {24'h0, trigger_channel_mask}, 32'hA5);

        spi_wr(7'd5, 8'h3C, 22);
        check_outs("extra");
        spi_wr(7'd0, 8'hFF, 16);
        spi_rd(7'd0);
        spi_wr(7'd11, 8'h77, 16);
        spi_rd(7'd11);

        trigger_in = 1'b1;
        spi_wr(7'd3, 8'h03, 16);
        trigger_in = 1'b0;
        #5;
        check_outs("trig_win");

        spi_wr(7'd9, 8'h01, 16);
        spi_wr(7'd3, 8'h03, 16);
        check_outs("pll_unlk");
        pll_locked = 1'b1;
        #5;
        check_outs("pll_lk");
        spi_rd(7'd0);

        for (int i = 0; i < 24; i++) begin
            logic [6:0] a;
            logic [7:0] d;
            a = 7'($urandom_range(0, 12));
            d = 8'($urandom);
            spi_wr(a, d, 16);
            spi_rd(a);
        end
        check_outs("rand");

        fork
            spi_wr(7'd1, 8'h3F, 16);
            begin
                #100;
                rstn = 1'b0;
                #20;
                rstn = 1'b1;
            end
        join
        m_reset();
        check_outs("midrst");
        spi_rd(7'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
